// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: fetch FSM encodings,
// the NOP used as the idle instruction, and the enable levels used across
// the codebase.
package if_fetch_pkg;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INST     = 32'h00000013;

  localparam logic        RST_ENABLE   = 1'b1;
  localparam logic        READ_ENABLE  = 1'b1;
  localparam logic        READ_DISABLE = 1'b0;

  // Number of byte beats that make up one instruction.
  localparam logic [2:0]  INST_BYTES   = 3'd4;

  typedef enum logic {
    IF_FETCH = 1'b0,  // issuing and collecting bytes
    IF_HOLD  = 1'b1   // instruction valid, waiting for decode
  } fetch_state_e;

  // Saturation is never needed: callers only step counters below INST_BYTES.
  function automatic logic [2:0] cnt_inc(input logic [2:0] cnt);
    return cnt + 3'd1;
  endfunction

endpackage

// File: rtl/if_fetch_if.sv
// Signal bundle between the fetch stage and its neighbours: the byte-wide
// memory arbiter port, the execute-stage redirect and the decode handshake.
interface if_fetch_if #(
  parameter int ADDR_WIDTH = 32
) ();

  logic                  mem_req_out;
  logic [ADDR_WIDTH-1:0] mem_addr_out;
  logic                  mem_grant_in;
  logic [7:0]            mem_data_in;
  logic                  redirect_in;
  logic [ADDR_WIDTH-1:0] redirect_pc_in;
  logic                  id_ready_in;
  logic                  inst_valid_out;
  logic [31:0]           inst_out;
  logic [ADDR_WIDTH-1:0] pc_out;

  // Fetch stage side.
  modport master (
    output mem_req_out, mem_addr_out, inst_valid_out, inst_out, pc_out,
    input  mem_grant_in, mem_data_in, redirect_in, redirect_pc_in, id_ready_in
  );

  // Environment side (arbiter, execute, decode).
  modport slave (
    input  mem_req_out, mem_addr_out, inst_valid_out, inst_out, pc_out,
    output mem_grant_in, mem_data_in, redirect_in, redirect_pc_in, id_ready_in
  );

endinterface

// File: rtl/if_fetch.sv
// Instruction-fetch stage. Reads a 32-bit instruction as four little-endian
// bytes through a pipelined byte port, presents it to decode with a
// valid/ready handshake and honours PC redirects from execute at any time.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  if_fetch_if.master  fetch_bus
);

  fetch_state_e          r_state;
  logic [2:0]            r_issue_cnt;
  logic [2:0]            r_recv_cnt;
  logic                  r_pending;
  logic [ADDR_WIDTH-1:0] r_fetch_pc;
  logic                  r_valid;
  logic [31:0]           r_inst;
  logic [ADDR_WIDTH-1:0] r_pc;

  logic                  w_mem_req;
  logic                  w_grant;
  logic                  w_recv;
  logic                  w_done;
  logic [31:0]           w_word;

  // Request/receive qualifiers. A redirect suppresses the request in its own
  // cycle and kills the byte returning in it.
  always_comb begin
    w_mem_req = (r_state == IF_FETCH) && (r_issue_cnt < INST_BYTES) &&
                !fetch_bus.redirect_in;
    w_grant   = w_mem_req && fetch_bus.mem_grant_in;
    w_recv    = r_pending && !fetch_bus.redirect_in;
    w_done    = w_recv && (r_recv_cnt == INST_BYTES - 3'd1);
  end

  // Lower three byte lanes are captured as they arrive; the top byte is taken
  // straight from the port on the completing edge, so it needs no register.
  for (genvar gi = 0; gi < 3; gi++) begin : g_lane
    logic [7:0] r_byte;

    // Capture byte gi of the instruction when it returns.
    always_ff @(posedge clk_in) begin
      if (rst_in == RST_ENABLE) begin
        r_byte <= 8'h00;
      end else if (w_recv && (r_recv_cnt == 3'(gi))) begin
        r_byte <= fetch_bus.mem_data_in;
      end
    end
  end

  assign w_word = {fetch_bus.mem_data_in, g_lane[2].r_byte,
                   g_lane[1].r_byte, g_lane[0].r_byte};

  // Fetch FSM: issue/collect bytes, hold for decode, redirect overrides all.
  always_ff @(posedge clk_in) begin
    if (rst_in == RST_ENABLE) begin
      r_state     <= IF_FETCH;
      r_issue_cnt <= 3'd0;
      r_recv_cnt  <= 3'd0;
      r_pending   <= 1'b0;
      r_fetch_pc  <= RESET_PC;
      r_valid     <= 1'b0;
      r_inst      <= NOP_INST;
      r_pc        <= RESET_PC;
    end else if (fetch_bus.redirect_in) begin
      // Whatever is held or in flight is wrong-path; inst/pc keep their values.
      r_state     <= IF_FETCH;
      r_issue_cnt <= 3'd0;
      r_recv_cnt  <= 3'd0;
      r_pending   <= 1'b0;
      r_fetch_pc  <= fetch_bus.redirect_pc_in;
      r_valid     <= 1'b0;
    end else begin
      r_pending <= w_grant;
      case (r_state)
        IF_FETCH: begin
          if (w_done) begin
            r_inst      <= w_word;
            r_pc        <= r_fetch_pc;
            r_valid     <= 1'b1;
            r_state     <= IF_HOLD;
            r_issue_cnt <= 3'd0;
            r_recv_cnt  <= 3'd0;
          end else begin
            // Issue and receive proceed independently so bytes pipeline.
            if (w_grant) begin
              r_issue_cnt <= cnt_inc(r_issue_cnt);
            end
            if (w_recv) begin
              r_recv_cnt <= cnt_inc(r_recv_cnt);
            end
          end
        end
        IF_HOLD: begin
          if (r_valid && fetch_bus.id_ready_in) begin
            r_valid    <= 1'b0;
            r_fetch_pc <= r_fetch_pc + ADDR_WIDTH'(4);
            r_state    <= IF_FETCH;
          end
        end
        default: r_state <= IF_FETCH;
      endcase
    end
  end

  assign fetch_bus.mem_req_out    = w_mem_req ? READ_ENABLE : READ_DISABLE;
  assign fetch_bus.mem_addr_out   = r_fetch_pc + ADDR_WIDTH'(r_issue_cnt);
  assign fetch_bus.inst_valid_out = r_valid;
  assign fetch_bus.inst_out       = r_inst;
  assign fetch_bus.pc_out         = r_pc;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed scenarios followed by randomized grant, ready,
// redirect and reset traffic, all compared cycle by cycle against a
// transaction-level model of the fetch stage and a byte memory image.
module tb_if_fetch;

  localparam int          AW     = 32;
  localparam logic [31:0] RST_PC = 32'h0;
  localparam logic [31:0] NOP    = 32'h00000013;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  if_fetch_if #(.ADDR_WIDTH(AW)) bus ();

  if_fetch #(.ADDR_WIDTH(AW), .RESET_PC(RST_PC)) dut (
    .clk_in    (clk),
    .rst_in    (rst),
    .fetch_bus (bus)
  );

  // Byte memory image, indexed by the low address byte.
  logic [7:0] mem_img [256];

  int n_vec = 0;
  int n_err = 0;

  // Model state: where fetching is, how many beats granted/arrived, and
  // what decode should currently see.
  bit          m_known   = 1'b0;
  logic [31:0] m_pc;
  int          m_granted;
  int          m_arrived;
  bit          m_pend;
  bit          m_valid;
  logic [31:0] m_inst;
  logic [31:0] m_out_pc;

  // Arbiter responder: returns the byte for whatever was granted last cycle.
  bit          resp_valid = 1'b0;
  logic [31:0] resp_addr  = '0;

  // Last sampled DUT outputs, for directed checks.
  logic        obs_valid;
  logic [31:0] obs_inst;
  logic [31:0] obs_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = '0;
    for (int k = 0; k < 4; k++) begin
      logic [31:0] b;
      b = a + 32'(k);
      w[8*k +: 8] = mem_img[b[7:0]];
    end
    return w;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] act,
                           input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs, advance the model.
  task automatic step(input bit s_rst, input bit s_redir,
                      input logic [31:0] s_rpc, input bit s_grant,
                      input bit s_ready);
    bit exp_req;
    bit g;
    @(negedge clk);
    rst                = s_rst;
    bus.redirect_in    = s_redir;
    bus.redirect_pc_in = s_rpc;
    bus.mem_grant_in   = s_grant;
    bus.id_ready_in    = s_ready;
    bus.mem_data_in    = resp_valid ? mem_img[resp_addr[7:0]] : 8'($urandom);
    #1;
    obs_valid = bus.inst_valid_out;
    obs_inst  = bus.inst_out;
    obs_pc    = bus.pc_out;

    exp_req = !m_valid && (m_granted < 4) && !s_redir;
    if (m_known) begin
      check_val("valid", {31'b0, bus.inst_valid_out}, {31'b0, m_valid});
      check_val("inst", bus.inst_out, m_inst);
      check_val("pc", bus.pc_out, m_out_pc);
      check_val("req", {31'b0, bus.mem_req_out}, {31'b0, exp_req});
      if (exp_req) begin
        check_val("addr", bus.mem_addr_out, m_pc + 32'(m_granted));
      end
    end

    g          = m_known && exp_req && s_grant;
    resp_valid = g;
    resp_addr  = m_pc + 32'(m_granted);

    if (s_rst) begin
      m_known   = 1'b1;
      m_pc      = RST_PC;
      m_granted = 0;
      m_arrived = 0;
      m_pend    = 1'b0;
      m_valid   = 1'b0;
      m_inst    = NOP;
      m_out_pc  = RST_PC;
    end else if (m_known && s_redir) begin
      m_pc      = s_rpc;
      m_granted = 0;
      m_arrived = 0;
      m_pend    = 1'b0;
      m_valid   = 1'b0;
    end else if (m_known) begin
      if (m_pend) m_arrived++;
      if (g) m_granted++;
      m_pend = g;
      if (m_arrived == 4) begin
        m_inst    = mem_word(m_pc);
        m_out_pc  = m_pc;
        m_valid   = 1'b1;
        m_granted = 0;
        m_arrived = 0;
        $display("inst pc=%h word=%h", m_out_pc, m_inst);
      end else if (m_valid && s_ready) begin
        m_valid = 1'b0;
        m_pc    = m_pc + 32'd4;
      end
    end
  endtask

  initial begin
    rst                = 1'b1;
    bus.redirect_in    = 1'b0;
    bus.redirect_pc_in = '0;
    bus.mem_grant_in   = 1'b0;
    bus.id_ready_in    = 1'b0;
    bus.mem_data_in    = '0;
    for (int i = 0; i < 256; i++) mem_img[i] = 8'($urandom);
    mem_img[0] = 8'h13;
    mem_img[1] = 8'h05;
    mem_img[2] = 8'h10;
    mem_img[3] = 8'h00;

    // Reset then free-running grants: valid in cycle 6.
    step(1, 0, 0, 1, 0);
    repeat (5) step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    check_val("tp_valid", {31'b0, obs_valid}, 32'd1);
    check_val("tp_inst", obs_inst, 32'h00100513);
    check_val("tp_pc", obs_pc, 32'h0);

    // Decode stalls for 5 cycles, then accepts; next fetch at 4.
    repeat (4) step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 1);
    repeat (5) step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    check_val("tp_pc4", obs_pc, 32'h4);
    check_val("tp_inst4", obs_inst, mem_word(32'h4));

    // Grant gap on the 2nd and 3rd requests: valid arrives 2 cycles late.
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    repeat (3) step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    check_val("tp_stall_v7", {31'b0, obs_valid}, 32'd0);
    step(0, 0, 0, 1, 0);
    check_val("tp_stall_v8", {31'b0, obs_valid}, 32'd1);
    check_val("tp_stall_pc", obs_pc, 32'h8);

    // Redirect after two bytes received: partial word dropped.
    step(0, 0, 0, 1, 1);
    repeat (3) step(0, 0, 0, 1, 0);
    step(0, 1, 32'h100, 1, 0);
    repeat (5) step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    check_val("tp_redir_pc", obs_pc, 32'h100);
    check_val("tp_redir_inst", obs_inst, mem_word(32'h100));

    // Redirect together with the decode handshake: redirect target wins.
    step(0, 1, 32'h200, 1, 1);
    repeat (5) step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    check_val("tp_hs_redir_pc", obs_pc, 32'h200);

    // Reset with three bytes issued and one pending.
    step(0, 0, 0, 1, 1);
    repeat (3) step(0, 0, 0, 1, 0);
    step(1, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    check_val("tp_rst_valid", {31'b0, obs_valid}, 32'd0);
    repeat (4) step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    check_val("tp_rst_pc", obs_pc, 32'h0);
    check_val("tp_rst_inst", obs_inst, 32'h00100513);

    // Randomized traffic, including misaligned redirect targets.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 19) == 0,
           $urandom, $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage. Produces the `pc`/`inst` pair consumed by the decode stage.
- Reads one 32-bit instruction as four little-endian bytes from the byte-wide memory port behind the memory arbiter.
- Hands the instruction to decode with a valid/ready handshake.
- Accepts PC redirects from the execute stage (branches and jumps).

Parameters:
- ADDR_WIDTH, 32, width of PC and memory address.
- RESET_PC, 32'h0, PC loaded on reset.

Ports:
- clk_in  input  1  clock; all state updates on the rising edge.
- rst_in  input  1  synchronous, active-high reset.
- mem_req_out  input/output: output  1  byte read request to the arbiter.
- mem_addr_out  output  ADDR_WIDTH  byte address for the current request.
- mem_grant_in  input  1  arbiter accepted the request this cycle.
- mem_data_in  input  8  read byte; valid the cycle after a granted request.
- redirect_in  input  1  execute stage demands a PC change.
- redirect_pc_in  input  ADDR_WIDTH  new PC when redirect_in=1.
- id_ready_in  input  1  decode accepts inst_out this cycle.
- inst_valid_out  output  1  inst_out/pc_out hold a complete instruction.
- inst_out  output  32  fetched instruction.
- pc_out  output  ADDR_WIDTH  address of inst_out.

Behaviour:
- **Reset** (rst_in=1 at an edge):
  - Outputs: pc_out=RESET_PC, inst_out=`NOPInst (32'h00000013), inst_valid_out=0.
  - Internal: state=FETCH, issue_cnt=0, recv_cnt=0, pending=0, fetch_pc=RESET_PC.
  - Reset mid-fetch discards all in-flight bytes. A byte returned the cycle after reset is ignored.
- **States:** FETCH (issuing/collecting bytes) and HOLD (instruction valid, waiting for decode).
- **Requests (combinational outputs):**
  - mem_req_out = (state==FETCH) && (issue_cnt<4) && !redirect_in.
  - mem_addr_out = fetch_pc + issue_cnt.
  - A request with mem_grant_in=1 increments issue_cnt and sets pending<=1. Otherwise pending<=0.
  - Requests are pipelined: byte k+1 may issue in the same cycle byte k returns.
- **Receive:** when pending=1, mem_data_in goes into inst_buf[8*recv_cnt+7 : 8*recv_cnt] and recv_cnt increments.
- **Completion:** on the edge where recv_cnt goes 3→4:
  - inst_out<=assembled word, pc_out<=fetch_pc, inst_valid_out<=1.
  - state<=HOLD; issue_cnt and recv_cnt reset to 0.
- **Grant gaps:** a cycle with mem_grant_in=0 just delays. Already-granted bytes still arrive the next cycle.
- **Handshake:** in HOLD with inst_valid_out && id_ready_in:
  - inst_valid_out<=0, fetch_pc<=fetch_pc+4 (wraps modulo 2^ADDR_WIDTH), state<=FETCH.
  - inst_out/pc_out keep their last value while invalid.
- **Latency:** with no grant stalls, handshake at cycle 0 gives:
  - bytes issued in cycles 1–4;
  - bytes returned in cycles 2–5;
  - inst_valid_out=1 in cycle 6.
  - Throughput is one instruction per 6 cycles.
- **Redirect** (redirect_in=1 in any state):
  - fetch_pc<=redirect_pc_in, state<=FETCH, counters<=0, pending<=0, inst_valid_out<=0.
  - No request is driven in the redirect cycle.
  - A byte returning in the cycle after the redirect is discarded (pending was cleared).
- **Simultaneous events:**
  - Redirect together with a decode handshake: redirect wins. The held instruction is treated as wrong-path; the consumed beat is still legal, but the PC comes from redirect_pc_in, not +4.
  - Redirect together with the completing byte: the byte is dropped and no valid is raised.
- **Misalignment:** redirect_pc_in is not checked. A misaligned PC is fetched byte-wise as given.

Decomposition:
- Shared defines header gets:
  - `NOPInst (32'h00000013);
  - fetch state encodings `IfFetch/`IfHold;
  - `RstEnable=1'b1 and `ReadEnable/`ReadDisable, already used codebase-wide.
- Single module; no sub-module needed. Byte assembly is a 4-entry shift/insert inside the block.

Test Plan:
- Reset, then grant always 1, memory bytes at 0..3 = 13 05 10 00 → mem_addr_out 0,1,2,3 in cycles 1–4; inst_valid_out=1 in cycle 6 with inst_out=32'h00100513, pc_out=0.
- Hold id_ready_in=0 for 5 cycles after valid → inst_out stable, no mem_req_out. Raise id_ready_in → next fetch at addresses 4..7, pc_out=4.
- mem_grant_in=0 on the 2nd and 3rd requests → mem_addr_out stays 1 across the stall; assembled word is still correct; valid is delayed by 2 cycles.
- redirect_in=1 with redirect_pc_in=32'h100 after 2 bytes received → partial bytes dropped, next requests 0x100..0x103, pc_out=32'h100.
- Redirect in the same cycle as the decode handshake in HOLD → next fetch starts at redirect_pc_in, not pc+4.
- Assert rst_in while issue_cnt=3 with a byte pending → next cycle inst_valid_out=0, fetch restarts at RESET_PC, stale byte ignored.
